servant_timer_sched: RTL
========================

SERVANT_TIMER_SCHED -- requirements
Module: servant_timer_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the width of the timer compare slice and of every deadline.
REQ-002 The block SHALL have parameter SLOTS, fixed at 4, meaning the number of software deadline slots.
REQ-003 Port i_clk  input  1  the single clock; all state on its rising edge.
REQ-004 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port i_wb_cyc  input  1  cycle strobe on the config bus.
REQ-006 Port i_wb_we  input  1  write enable on the config bus.
REQ-007 Port i_wb_adr  input  3  register select.
REQ-008 Port i_wb_dat  input  32  write data.
REQ-009 Port o_wb_dat  output  32  read data.
REQ-010 Port o_wb_ack  output  1  single-cycle acknowledge.
REQ-011 Port o_tmr_cyc / o_tmr_we  output  1 each  write strobe to the timer compare register.
REQ-012 Port o_tmr_dat  output  32  compare value; bits 31:WIDTH are zero.
REQ-013 Port i_tmr_irq  input  1  registered timer "mtime >= compare" flag.
REQ-014 Port o_irq  output  1  scheduler interrupt.

Function
REQ-015 Address map: 0-3 are slot deadlines; 4 is status; 5 is IE (Configuration); 6-7 read zero, and writes to them are ignored.
REQ-016 Writing address n (0-3) SHALL load deadline[n] <= i_wb_dat[WIDTH-1:0], set armed[n], and clear expired[n].
REQ-017 Reading address 4 SHALL return {armed in 11:8, expired in 3:0}, with all other bits zero.
REQ-018 Writing address 4 SHALL treat bits 3:0 as write-1-to-clear of expired and bits 11:8 as write-1-to-cancel of armed.
REQ-019 Reading address n (0-3) SHALL return the zero-extended deadline[n].
REQ-020 o_wb_ack SHALL be i_wb_cyc & !o_wb_ack, registered, giving one-cycle latency; register effects take place on the ack cycle.
REQ-021 The FSM SHALL have the states IDLE, SCAN, PROG, SETTLE and WAIT.
REQ-022 IDLE: if armed != 0, go to SCAN; otherwise stay in IDLE. i_tmr_irq is ignored.
REQ-023 SCAN: visit one slot per cycle, index 0..3 (4 cycles), tracking the armed slot with the smallest unsigned deadline; on a tie the lower index wins.
   - After slot 3: if no slot is armed, go to IDLE; otherwise latch sel and go to PROG.
REQ-024 PROG: assert o_tmr_cyc=o_tmr_we=1 for exactly one cycle with o_tmr_dat=deadline[sel], then go to SETTLE.
REQ-025 SETTLE: one cycle with i_tmr_irq ignored (the stale flag from the old compare), then go to WAIT.
REQ-026 WAIT: on i_tmr_irq=1, set expired[sel], clear armed[sel], and go to SCAN.
REQ-027 Any accepted config write in SCAN, PROG, SETTLE or WAIT SHALL restart SCAN from slot 0 on the next cycle.
   - PROG still completes its single strobe before the restart.
REQ-028 Simultaneous events in WAIT:
   - i_tmr_irq together with a deadline write to sel: the write wins; the slot stays armed with the new deadline and is not expired.
   - i_tmr_irq together with a write to another slot: both effects apply.
REQ-029 Cancelling armed[sel] in WAIT SHALL prevent its expiry; the FSM rescans.
REQ-030 o_irq SHALL be registered: o_irq <= |(expired & ie_mask).
REQ-031 o_tmr_cyc and o_tmr_we SHALL be zero outside PROG.

Reset
REQ-032 While i_rst_n=0, the block SHALL force:
   - FSM=IDLE, with scan index and sel at 0;
   - armed=0, expired=0, deadlines=0, IE=0;
   - o_wb_ack=0, o_tmr_cyc=0, o_tmr_we=0, o_tmr_dat=0, o_irq=0.
   This applies asynchronously and includes reset in the middle of any state.
REQ-033 After reset release, the first state change SHALL occur on the first rising edge with i_rst_n=1.

Configuration
REQ-034 With macro SERVANT_TIMER_SCHED_IE_EN defined, address 5 SHALL be a 4-bit read/write register ie, and ie_mask=ie.
REQ-035 Without SERVANT_TIMER_SCHED_IE_EN, address 5 SHALL read zero, writes to it SHALL be ignored, and ie_mask=4'hF.

Verification
REQ-036 Write slot0=100 and slot2=40; the timer model reaches 40 -> one PROG strobe with o_tmr_dat=40 and then one with o_tmr_dat=100; status reads expired=0x4 then 0x5; o_irq=1 (IE=0xF).
REQ-037 Arm slots 1 and 3 both =50 -> sel=1 is programmed first; slot 3 expires on the following rescan.
REQ-038 In WAIT on slot0=200, write slot1=30 -> the FSM rescans and programs 30; slot1 expires before slot0.
REQ-039 Drive i_tmr_irq=1 in the same cycle as a write of slot sel=500 -> expired[sel]=0, armed[sel]=1, and 500 is reprogrammed.
REQ-040 Assert i_tmr_irq=1 during SETTLE only -> no expiry; then write status 0x100 to cancel slot0 in WAIT -> FSM goes to IDLE with no strobe.
REQ-041 Pulse i_rst_n low during PROG -> o_tmr_cyc drops immediately and all status reads 0; with SERVANT_TIMER_SCHED_IE_EN defined and IE=0, an expiry leaves o_irq=0.

Source files
------------

// File: rtl/servant_timer_sched.sv
// Four-slot software deadline scheduler that multiplexes one hardware timer compare register.
// Optional feature: define SERVANT_TIMER_SCHED_IE_EN for a read/write interrupt-enable register at address 5.
module servant_timer_sched #(
  parameter int WIDTH = 16,
  parameter int SLOTS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_tmr_cyc,
  output logic        o_tmr_we,
  output logic [31:0] o_tmr_dat,
  input  logic        i_tmr_irq,
  output logic        o_irq
);

  typedef enum logic [2:0] {IDLE, SCAN, PROG, SETTLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       best_q, best_d;
  logic [1:0]       sel_q, sel_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] best_dl_q, best_dl_d;
  logic [WIDTH-1:0] deadline_q [SLOTS];
  logic [WIDTH-1:0] deadline_d [SLOTS];
  logic [SLOTS-1:0] armed_q, armed_d;
  logic [SLOTS-1:0] expired_q, expired_d;
  logic [SLOTS-1:0] ie_mask;
  logic             ack_q, ack_d;
  logic             tmr_cyc_q, tmr_cyc_d;
  logic [WIDTH-1:0] tmr_dat_q, tmr_dat_d;
  logic             irq_q, irq_d;

  logic             wr;
  logic             take;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [WIDTH-1:0] win_dl;
  logic             expire;
  logic             unused_dat;

`ifdef SERVANT_TIMER_SCHED_IE_EN
  logic [SLOTS-1:0] ie_q, ie_d;
  assign ie_mask = ie_q;
`else
  assign ie_mask = '1;
`endif

  assign unused_dat = ^i_wb_dat;
  assign wr         = i_wb_cyc & i_wb_we & ack_q;

  // Running minimum over the slot visited this cycle; strict '<' keeps the lower index on ties.
  assign take      = armed_q[idx_q] && (!found_q || (deadline_q[idx_q] < best_dl_q));
  assign win_found = found_q | take;
  assign win_idx   = take ? idx_q : best_q;
  assign win_dl    = take ? deadline_q[idx_q] : best_dl_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    best_d    = best_q;
    sel_d     = sel_q;
    found_d   = found_q;
    best_dl_d = best_dl_q;
    deadline_d = deadline_q;
    armed_d   = armed_q;
    expired_d = expired_q;
`ifdef SERVANT_TIMER_SCHED_IE_EN
    ie_d      = ie_q;
`endif
    ack_d     = i_wb_cyc & ~ack_q;
    tmr_cyc_d = 1'b0;
    tmr_dat_d = tmr_dat_q;
    irq_d     = |(expired_q & ie_mask);
    expire    = (state_q == WAIT) && i_tmr_irq && armed_q[sel_q];

    case (state_q)
      IDLE: begin
        if (|armed_q) state_d = SCAN;
      end
      SCAN: begin
        found_d   = win_found;
        best_d    = win_idx;
        best_dl_d = win_dl;
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          found_d = 1'b0;
          if (win_found) begin
            sel_d     = win_idx;
            state_d   = PROG;
            tmr_cyc_d = 1'b1;
            tmr_dat_d = win_dl;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      PROG:    state_d = SETTLE;
      SETTLE:  state_d = WAIT;
      WAIT: begin
        if (i_tmr_irq) state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase

    // A rewrite or cancel of the pending slot overrides a coincident timer hit.
    if (wr) begin
      if (!i_wb_adr[2]) begin
        deadline_d[i_wb_adr[1:0]] = i_wb_dat[WIDTH-1:0];
        armed_d[i_wb_adr[1:0]]    = 1'b1;
        expired_d[i_wb_adr[1:0]]  = 1'b0;
        if (i_wb_adr[1:0] == sel_q) expire = 1'b0;
      end else if (i_wb_adr == 3'd4) begin
        expired_d = expired_d & ~i_wb_dat[3:0];
        armed_d   = armed_d & ~i_wb_dat[11:8];
        if (i_wb_dat[8 + sel_q]) expire = 1'b0;
      end
`ifdef SERVANT_TIMER_SCHED_IE_EN
      else if (i_wb_adr == 3'd5) begin
        ie_d = i_wb_dat[3:0];
      end
`endif
    end

    if (expire) begin
      expired_d[sel_q] = 1'b1;
      armed_d[sel_q]   = 1'b0;
    end

    if (wr && (state_q != IDLE)) begin
      state_d   = SCAN;
      idx_d     = 2'd0;
      found_d   = 1'b0;
      tmr_cyc_d = 1'b0;
      tmr_dat_d = tmr_dat_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      best_q    <= '0;
      sel_q     <= '0;
      found_q   <= 1'b0;
      best_dl_q <= '0;
      for (int i = 0; i < SLOTS; i++) deadline_q[i] <= '0;
      armed_q   <= '0;
      expired_q <= '0;
`ifdef SERVANT_TIMER_SCHED_IE_EN
      ie_q      <= '0;
`endif
      ack_q     <= 1'b0;
      tmr_cyc_q <= 1'b0;
      tmr_dat_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      best_q    <= best_d;
      sel_q     <= sel_d;
      found_q   <= found_d;
      best_dl_q <= best_dl_d;
      deadline_q <= deadline_d;
      armed_q   <= armed_d;
      expired_q <= expired_d;
`ifdef SERVANT_TIMER_SCHED_IE_EN
      ie_q      <= ie_d;
`endif
      ack_q     <= ack_d;
      tmr_cyc_q <= tmr_cyc_d;
      tmr_dat_q <= tmr_dat_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    o_wb_dat = '0;
    if (!i_wb_adr[2]) begin
      o_wb_dat = 32'(deadline_q[i_wb_adr[1:0]]);
    end else if (i_wb_adr == 3'd4) begin
      o_wb_dat = {20'd0, armed_q, 4'd0, expired_q};
    end
`ifdef SERVANT_TIMER_SCHED_IE_EN
    else if (i_wb_adr == 3'd5) begin
      o_wb_dat = {28'd0, ie_q};
    end
`endif
  end

  assign o_wb_ack  = ack_q;
  assign o_tmr_cyc = tmr_cyc_q;
  assign o_tmr_we  = tmr_cyc_q;
  assign o_tmr_dat = 32'(tmr_dat_q);
  assign o_irq     = irq_q;

endmodule
